load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit between the single-cycle core datapath and a word-organised data memory bus with variable latency. It accepts the datapath's data address, store data and access width, and drives a request/acknowledge bus. While an access is outstanding it stalls the core. It returns sign- or zero-extended load data on `read_data` and reports misaligned, illegal and timed-out accesses.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: number of BUSY cycles without `bus_ack` before the access is aborted. Range 1..255.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  load instruction present (control).
- `mem_write`  in  1  store instruction present (control).
- `funct3`  in  3  access width/signedness: instr[14:12].
- `data_addr`  in  16  byte address (ALU result).
- `write_data`  in  32  store data (register rs2).
- `read_data`  out  32  extended load data, valid in DONE.
- `stall`  out  1  freeze PC and suppress RegWrite.
- `fault`  out  1  access aborted, valid in DONE.
- `fault_cause`  out  2  01 misaligned, 10 timeout, 11 illegal.
- `bus_req`  out  1  request to memory.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  14  word address, data_addr[15:2].
- `bus_wdata`  out  32  lane-steered store data.
- `bus_be`  out  4  byte enables.
- `bus_ack`  in  1  memory completion.
- `bus_rdata`  in  32  memory read word, valid with `bus_ack`.

## Operation
FSM states: IDLE, BUSY, DONE.

- **IDLE**
  - An access is `mem_read | mem_write`.
  - On an access, `stall`=1 combinationally.
  - Legal and aligned access: latch address, we, be, wdata and funct3, then go to BUSY.
  - Misaligned (H with addr[0]=1; W with addr[1:0]≠0): go to DONE with fault, cause 01. No bus cycle.
  - Illegal: funct3 ∉ {000,001,010,100,101}, funct3 ∈ {100,101} on a store, or `mem_read & mem_write`. Go to DONE with fault, cause 11. No bus cycle.
- **BUSY**
  - `bus_req`=1 and `stall`=1.
  - `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` are held stable until `bus_ack` is sampled.
  - On `bus_ack`: loads capture the extracted and extended `bus_rdata` into `read_data`; stores capture nothing. Go to DONE.
  - Timeout counter increments each BUSY cycle. On reaching `TIMEOUT_CYCLES` without ack: `read_data`=0, fault cause 10, go to DONE.
- **DONE**
  - Lasts 1 cycle with `stall`=0, so the core retires the instruction.
  - `read_data`, `fault` and `fault_cause` are held.
  - Next state is always IDLE, so the same instruction never re-triggers.

Store lane steering:
- SB: `bus_be`=1<<addr[1:0]; `bus_wdata`=byte replicated ×4.
- SH: `bus_be`=addr[1] ? 1100 : 0011; `bus_wdata`=halfword replicated ×2.
- SW: `bus_be`=1111; `bus_wdata`=`write_data`.
- Loads: `bus_be`=1111.

Load extraction:
- LB and LBU select byte addr[1:0].
- LH and LHU select half addr[1].
- LB and LH sign-extend from bit 7 and bit 15 respectively.
- LBU and LHU zero-extend.

Boundary behaviour:
- `bus_ack` outside BUSY is ignored.
- Ack in the same cycle the timeout is reached: the ack wins, no fault.

## Timing
- Reset (asynchronous, immediate, also mid-access): state IDLE, timeout counter 0. All outputs 0: `read_data`, `fault`, `fault_cause`, `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`. `stall`=0. Any pending bus transaction is abandoned.
- Minimum access with ack in the first BUSY cycle: 3 cycles (IDLE, BUSY, DONE), of which 2 have `stall`=1.
- Access with ack after k BUSY cycles: k+2 cycles.
- Faulting access without a bus cycle: 2 cycles (IDLE stalled, DONE).
- Non-memory instructions: `stall`=0 and no latency added.
- `bus_req` rises on the clock edge that enters BUSY and falls on the edge that leaves it.

## Structure
- Shared package `lsu_pkg` holds:
  - the state encoding (IDLE/BUSY/DONE);
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - fault cause codes (`FC_MISALIGN`, `FC_TIMEOUT`, `FC_ILLEGAL`).
- One combinational sub-module, `lsu_lane_align`, performs store lane steering and byte-enable generation, plus load extraction and extension. The top level holds the FSM, the capture registers and the timeout counter.

## Test plan
- **SW then LW:** SW addr 0x0010, data 0xDEADBEEF, ack after 1 cycle -> `bus_be`=1111, `bus_addr`=0x004, `stall` high 2 cycles. Then LW from 0x0010 with `bus_rdata`=0xDEADBEEF -> `read_data`=0xDEADBEEF in DONE.
- **Byte loads:** `bus_rdata`=0x80FF7F01. LB at addr 3 -> 0xFFFFFF80. LBU at addr 3 -> 0x00000080. LH at addr 2 -> 0xFFFF80FF. LHU at addr 0 -> 0x00007F01.
- **Stores:** SB addr 0x0005, data 0x000000AB -> `bus_be`=0010, `bus_wdata`=0xABABABAB. SH addr 0x0006, data 0x1234 -> `bus_be`=1100.
- **Faults without a bus cycle:** LW addr 0x0002 -> no `bus_req`, DONE with fault, cause 01. funct3=011 -> fault, cause 11. `mem_read & mem_write` -> fault, cause 11.
- **Timeout and ack priority:** `TIMEOUT_CYCLES`=4, ack never given -> `bus_req` high exactly 4 cycles, fault cause 10, `read_data`=0. Ack given in the 4th BUSY cycle -> no fault.
- **Reset mid-access:** `reset` low mid-BUSY -> `bus_req` and `stall` drop immediately; after release, a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 access
// codes and fault cause codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_TIMEOUT  = 2'b10;
    localparam logic [1:0] FC_ILLEGAL  = 2'b11;

    // True for the five width encodings the unit understands.
    function automatic logic f3_is_known(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store data steering / byte enables and
// load byte/halfword extraction with sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shift;
    logic [15:0] w_ld_half;

    // Store steering: replicate narrow data across the word, enable only target lanes.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        if (i_is_store) begin
            case (i_st_funct3[1:0])
                2'b00: begin
                    o_be    = 4'b0001 << i_st_addr_lo;
                    o_wdata = {4{i_st_data[7:0]}};
                end
                2'b01: begin
                    o_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_st_data[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_st_data;
                end
            endcase
        end
    end

    // Load extraction: pick the addressed byte/half and extend to 32 bits.
    always_comb begin
        w_ld_shift = i_rdata >> {i_ld_addr_lo, 3'b000};
        w_ld_half  = i_ld_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            F3_BU:   o_ld_data = {24'h0, w_ld_shift[7:0]};
            F3_H:    o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            F3_HU:   o_ld_data = {16'h0, w_ld_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/BUSY/DONE handshake FSM between the core datapath and
// a variable-latency request/acknowledge memory bus, with timeout abort.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [15:0] data_addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [13:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;

    logic        w_access;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_timeout_hit;
    logic [1:0]  w_fault_cause;

    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;

    logic [7:0]  r_tcount;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic        r_is_load;
    logic [31:0] r_read_data;
    logic        r_fault;
    logic [1:0]  r_fault_cause;
    logic        r_bus_we;
    logic [13:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;

    assign w_access  = mem_read | mem_write;
    assign w_illegal = (mem_read & mem_write) | ~f3_is_known(funct3) |
                       (mem_write & funct3[2]);
    assign w_misalign = (funct3[1:0] == 2'b01) ? data_addr[0] :
                        (funct3[1:0] == 2'b10) ? (data_addr[1:0] != 2'b00) : 1'b0;
    assign w_timeout_hit = (r_tcount == TO_LAST);

    lsu_lane_align u_lane_align (
        .i_is_store   (mem_write),
        .i_st_funct3  (funct3),
        .i_st_addr_lo (data_addr[1:0]),
        .i_st_data    (write_data),
        .o_be         (w_st_be),
        .o_wdata      (w_st_wdata),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_rdata      (bus_rdata),
        .o_ld_data    (w_ld_data)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic and fault classification for a new access.
    always_comb begin
        w_next_state  = r_state;
        w_fault_cause = FC_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_illegal) begin
                        w_next_state  = ST_DONE;
                        w_fault_cause = FC_ILLEGAL;
                    end else if (w_misalign) begin
                        w_next_state  = ST_DONE;
                        w_fault_cause = FC_MISALIGN;
                    end else begin
                        w_next_state = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (bus_ack || w_timeout_hit) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Capture registers, timeout counter and held bus request fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcount      <= '0;
            r_funct3      <= '0;
            r_addr_lo     <= '0;
            r_is_load     <= 1'b0;
            r_read_data   <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= '0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_bus_be      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        if (w_fault_cause != FC_NONE) begin
                            r_fault       <= 1'b1;
                            r_fault_cause <= w_fault_cause;
                            r_read_data   <= '0;
                        end else begin
                            r_fault       <= 1'b0;
                            r_fault_cause <= FC_NONE;
                            r_tcount      <= '0;
                            r_funct3      <= funct3;
                            r_addr_lo     <= data_addr[1:0];
                            r_is_load     <= mem_read;
                            r_bus_we      <= mem_write;
                            r_bus_addr    <= data_addr[15:2];
                            r_bus_wdata   <= w_st_wdata;
                            r_bus_be      <= w_st_be;
                        end
                    end
                end
                ST_BUSY: begin
                    // Ack takes priority over a timeout reached in the same cycle.
                    if (bus_ack) begin
                        if (r_is_load) r_read_data <= w_ld_data;
                    end else if (w_timeout_hit) begin
                        r_read_data   <= '0;
                        r_fault       <= 1'b1;
                        r_fault_cause <= FC_TIMEOUT;
                    end else begin
                        r_tcount <= r_tcount + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // stall is gated by reset so it drops immediately even with an access pending.
    assign stall       = reset & (((r_state == ST_IDLE) & w_access) | (r_state == ST_BUSY));
    assign bus_req     = (r_state == ST_BUSY);
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign bus_be      = r_bus_be;
    assign read_data   = r_read_data;
    assign fault       = r_fault;
    assign fault_cause = r_fault_cause;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [15:0] data_addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall, fault;
    logic [1:0]  fault_cause;
    logic        bus_req, bus_we;
    logic [13:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        stall;
        logic        req;
        logic        chk_bus;
        logic [13:0] addr;
        logic        we;
        logic [3:0]  be;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic        chk_done;
        logic        fault;
        logic [1:0]  cause;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .data_addr(data_addr), .write_data(write_data),
        .read_data(read_data), .stall(stall), .fault(fault), .fault_cause(fault_cause),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: what a load of width/sign f3 at byte offset a returns from word w.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned a,
                                               input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'b000: begin v = (w >> (8 * a)) & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFFFF00; end
            3'b100: v = (w >> (8 * a)) & 32'hFF;
            3'b001: begin v = (w >> (16 * (a / 2))) & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF0000; end
            3'b101: v = (w >> (16 * (a / 2))) & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic exp_t blank(input logic s, input logic r);
        exp_t e;
        e = '{stall: s, req: r, chk_bus: 0, addr: '0, we: 0, be: '0, chk_wdata: 0,
              wdata: '0, chk_done: 0, fault: 0, cause: '0, chk_rd: 0, rd: '0};
        return e;
    endfunction

    // Compare process: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("bus_req", 32'(bus_req), 32'(e.req));
            if (e.chk_bus) begin
                chk("bus_addr", 32'(bus_addr), 32'(e.addr));
                chk("bus_we", 32'(bus_we), 32'(e.we));
                chk("bus_be", 32'(bus_be), 32'(e.be));
                if (e.chk_wdata) chk("bus_wdata", bus_wdata, e.wdata);
            end
            if (e.chk_done) begin
                chk("fault", 32'(fault), 32'(e.fault));
                if (e.fault) chk("fault_cause", 32'(fault_cause), 32'(e.cause));
                if (e.chk_rd) chk("read_data", read_data, e.rd);
            end
        end
    end

    // Drive one instruction through to retirement. ack_at = BUSY cycle (1-based)
    // in which ack is given; 0 or beyond TO means never.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [15:0] addr, input logic [31:0] wd,
                             input int unsigned ack_at, input logic [31:0] rdata,
                             output logic [31:0] got_rd, output logic got_fault,
                             output logic [1:0] got_cause);
        exp_t e;
        logic illegal, misalign, known, acked;
        int unsigned width, a;
        logic [3:0] be;
        logic [31:0] wdat;

        known   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                  (f3 == 3'b100) || (f3 == 3'b101);
        illegal = (rd && wr) || !known || (wr && (f3 == 3'b100 || f3 == 3'b101));
        width   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        misalign = !illegal && ((addr % width) != 0);
        a = addr % 4;
        be = 4'hF;
        wdat = wd;
        if (wr && width == 1) begin be = 4'(1 << a); wdat = (wd & 32'hFF) * 32'h01010101; end
        if (wr && width == 2) begin be = (a >= 2) ? 4'hC : 4'h3; wdat = (wd & 32'hFFFF) * 32'h00010001; end

        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; data_addr = addr; write_data = wd;
        bus_ack = 1'($urandom % 2); bus_rdata = $urandom;
        exp_q.push_back(blank(1'b1, 1'b0));

        e = blank(1'b0, 1'b0);
        e.chk_done = 1'b1;
        if (illegal || misalign) begin
            @(posedge clk); #1;
            e.fault = 1'b1;
            e.cause = illegal ? 2'b11 : 2'b01;
        end else begin
            acked = 1'b0;
            for (int n = 1; n <= int'(TO); n++) begin
                @(posedge clk); #1;
                bus_ack = (n == int'(ack_at));
                bus_rdata = rdata;
                exp_q.push_back('{stall: 1, req: 1, chk_bus: 1, addr: addr / 4, we: wr, be: be,
                                  chk_wdata: wr, wdata: wdat, chk_done: 0, fault: 0,
                                  cause: '0, chk_rd: 0, rd: '0});
                if (bus_ack) begin acked = 1'b1; break; end
            end
            @(posedge clk); #1;
            bus_ack = 1'($urandom % 2);
            bus_rdata = $urandom;
            if (acked) begin
                e.fault = 1'b0;
                e.chk_rd = rd;
                e.rd = model_load(f3, a, rdata);
            end else begin
                e.fault = 1'b1;
                e.cause = 2'b10;
                e.chk_rd = 1'b1;
                e.rd = '0;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        got_rd = read_data; got_fault = fault; got_cause = fault_cause;

        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        bus_ack = 1'($urandom % 2);
        exp_q.push_back(blank(1'b0, 1'b0));
    endtask

    initial begin
        logic [31:0] r;
        logic f;
        logic [1:0] c;
        logic rd, wr;
        logic [2:0] f3;
        int unsigned sel;

        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; data_addr = '0;
        write_data = '0; bus_ack = 1'b0; bus_rdata = '0;
        #12;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_fault", 32'({fault, fault_cause}), 32'h0);
        chk("rst_bus", 32'({bus_req, bus_we, bus_be}), 32'h0);
        chk("rst_bus_addr", 32'(bus_addr), 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        @(posedge clk); #1 reset = 1'b1;

        do_access(0, 1, 3'b010, 16'h0010, 32'hDEADBEEF, 1, 32'h0, r, f, c);
        chk("sw_nofault", 32'(f), 32'h0);
        do_access(1, 0, 3'b010, 16'h0010, 32'h0, 1, 32'hDEADBEEF, r, f, c);
        chk("lw_data", r, 32'hDEADBEEF);
        do_access(1, 0, 3'b000, 16'h0003, 32'h0, 2, 32'h80FF7F01, r, f, c);
        chk("lb_data", r, 32'hFFFFFF80);
        do_access(1, 0, 3'b100, 16'h0003, 32'h0, 1, 32'h80FF7F01, r, f, c);
        chk("lbu_data", r, 32'h00000080);
        do_access(1, 0, 3'b001, 16'h0002, 32'h0, 3, 32'h80FF7F01, r, f, c);
        chk("lh_data", r, 32'hFFFF80FF);
        do_access(1, 0, 3'b101, 16'h0000, 32'h0, 1, 32'h80FF7F01, r, f, c);
        chk("lhu_data", r, 32'h00007F01);
        do_access(0, 1, 3'b000, 16'h0005, 32'h000000AB, 2, 32'h0, r, f, c);
        do_access(0, 1, 3'b001, 16'h0006, 32'h00001234, 1, 32'h0, r, f, c);
        do_access(1, 0, 3'b010, 16'h0002, 32'h0, 1, 32'h0, r, f, c);
        chk("misalign_cause", 32'({f, c}), 32'b101);
        do_access(1, 0, 3'b011, 16'h0000, 32'h0, 1, 32'h0, r, f, c);
        chk("illegal_f3_cause", 32'({f, c}), 32'b111);
        do_access(1, 1, 3'b010, 16'h0000, 32'h0, 1, 32'h0, r, f, c);
        chk("rdwr_cause", 32'({f, c}), 32'b111);
        do_access(1, 0, 3'b010, 16'h0040, 32'h0, 0, 32'h12345678, r, f, c);
        chk("timeout_cause", 32'({f, c}), 32'b110);
        chk("timeout_data", r, 32'h0);
        do_access(1, 0, 3'b010, 16'h0044, 32'h0, TO, 32'h12345678, r, f, c);
        chk("ack_at_limit", 32'({f, r}), 32'h12345678);

        // Reset in the middle of a bus cycle.
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; data_addr = 16'h0020; bus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_req", 32'(bus_req), 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 32'h0);
        chk("midrst_req", 32'(bus_req), 32'h0);
        chk("midrst_bus", 32'({bus_addr, bus_be}), 32'h0);
        mem_read = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        do_access(1, 0, 3'b010, 16'h0024, 32'h0, 2, 32'hCAFEF00D, r, f, c);
        chk("post_reset_lw", r, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 19);
            rd = (sel < 10) || (sel == 19);
            wr = (sel >= 10);
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if (rd && !wr && $urandom_range(0, 1) == 1 && f3 != 3'b010) f3[2] = 1'b1;
            do_access(rd, wr, f3, 16'($urandom), $urandom, $urandom_range(0, 6), $urandom, r, f, c);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
